// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite geometry, loader opcodes and loader FSM states.
package sprite_pkg;
  localparam int SPRITE_NUM = 8;
  localparam int SPRITE_SIZE = 4096;
  localparam int SPRITE_ADDR_SIZE = 11;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LOAD = 8'h01;
  typedef enum logic [1:0] {IDLE, SELECT, DATA, DRAIN} loader_state_t;
endpackage

// File: rtl/sprite_loader_if.sv
// sprite_loader_if: SPI byte stream in, sprite buffer writes and status out.
interface sprite_loader_if #(
  parameter int SPRITE_NUM = sprite_pkg::SPRITE_NUM,
  parameter int SPRITE_ADDR_SIZE = sprite_pkg::SPRITE_ADDR_SIZE
);
  logic rx_valid;
  logic [7:0] rx_data;
  logic frame_end;
  logic [$clog2(SPRITE_NUM)-1:0] w_select;
  logic w_en;
  logic [SPRITE_ADDR_SIZE:0] w_addr;
  logic [7:0] w_data;
  logic busy;
  logic done;
  logic err;
  modport master (
    input rx_valid, rx_data, frame_end,
    output w_select, w_en, w_addr, w_data, busy, done, err
  );
  modport slave (
    output rx_valid, rx_data, frame_end,
    input w_select, w_en, w_addr, w_data, busy, done, err
  );
endinterface

// File: rtl/sprite_loader.sv
// sprite_loader: parses LOAD_SPRITE commands and issues one registered byte write per data byte.
module sprite_loader #(
  parameter int SPRITE_NUM = sprite_pkg::SPRITE_NUM,
  parameter int SPRITE_SIZE = sprite_pkg::SPRITE_SIZE,
  parameter int SPRITE_ADDR_SIZE = sprite_pkg::SPRITE_ADDR_SIZE
) (
  input logic clock,
  input logic reset_n,
  sprite_loader_if.master bus
);
  import sprite_pkg::*;
  localparam int SW = $clog2(SPRITE_NUM);
  localparam int AW = SPRITE_ADDR_SIZE + 1;
  loader_state_t state, byte_state, nxt_state;
  logic [AW-1:0] cnt;
  logic sel_ok, wr, last, bad, aborted;
  always_comb begin
    sel_ok = state == SELECT && bus.rx_valid && 32'(bus.rx_data) < SPRITE_NUM;
    wr = state == DATA && bus.rx_valid;
    last = wr && cnt == AW'(SPRITE_SIZE - 2);
    bad = bus.rx_valid && ((state == IDLE && bus.rx_data != OP_NOP && bus.rx_data != OP_LOAD) ||
                           (state == SELECT && !sel_ok));
    byte_state = !bus.rx_valid ? state :
                 bad ? DRAIN :
                 (state == IDLE && bus.rx_data == OP_LOAD) ? SELECT :
                 sel_ok ? DATA :
                 last ? IDLE : state;
    // frame_end acts on the state left behind by a coincident byte
    aborted = bus.frame_end && (byte_state == SELECT || byte_state == DATA);
    nxt_state = bus.frame_end ? IDLE : byte_state;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.w_select <= '0;
      bus.w_en <= 1'b0;
      bus.w_addr <= '0;
      bus.w_data <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= nxt_state;
      bus.w_en <= wr;
      bus.done <= last;
      bus.err <= bad || aborted;
      bus.busy <= nxt_state != IDLE;
      if (sel_ok) begin
        bus.w_select <= SW'(bus.rx_data);
        cnt <= '0;
      end
      if (wr) begin
        bus.w_addr <= cnt;
        bus.w_data <= bus.rx_data;
        cnt <= cnt + AW'(2);
      end
    end
  end
endmodule
